// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_sb
//  Function : Parametrised register file, 2**ADDR_W x WIDTH. Two registered
//             read ports with write-first bypass, optional hard-wired zero
//             entry, multi-cycle bulk-clear sequencer, and a per-entry
//             pending-write scoreboard for read-after-reserve hazard detection.
//  Revision : 1.0  initial release
// ============================================================================
module regfile_sb #(
    parameter int WIDTH    = 8,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [WIDTH-1:0]  rd_data1,
    output logic [WIDTH-1:0]  rd_data2,
    output logic              rd_valid,
    output logic              rd_hazard1,
    output logic              rd_hazard2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic              clr_req,
    output logic              busy,
    output logic [ADDR_W:0]   pend_count
);

    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam bit                HAS_ZERO = (ZERO_REG != 0);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [DEPTH-1:0]  pend_q, pend_d;
    logic [ADDR_W:0]   pend_count_q, pend_count_d;

    logic [WIDTH-1:0]  rd_data1_q, rd_data1_d;
    logic [WIDTH-1:0]  rd_data2_q, rd_data2_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_hazard1_q, rd_hazard1_d;
    logic              rd_hazard2_q, rd_hazard2_d;

    logic              idle;
    logic              wr_ok;
    logic              rsv_ok;
    logic              zero1;
    logic              zero2;

    // A clear request in IDLE pre-empts any write/reservation in the same cycle;
    // entry 0 silently drops writes and reservations when it is hard-wired.
    assign idle   = (state_q == ST_IDLE);
    assign wr_ok  = idle && wr_en  && !clr_req && !(HAS_ZERO && (wr_addr  == '0));
    assign rsv_ok = idle && rsv_en && !clr_req && !(HAS_ZERO && (rsv_addr == '0));
    assign zero1  = HAS_ZERO && (rd_addr1 == '0);
    assign zero2  = HAS_ZERO && (rd_addr2 == '0);

    // Read path: write-first bypass, hazard from pre-edge pending bits, hold when idle.
    always_comb begin
        rd_valid_d   = 1'b0;
        rd_data1_d   = rd_data1_q;
        rd_data2_d   = rd_data2_q;
        rd_hazard1_d = rd_hazard1_q;
        rd_hazard2_d = rd_hazard2_q;
        if (idle && rd_en) begin
            rd_valid_d = 1'b1;
            if (zero1) begin
                rd_data1_d   = '0;
                rd_hazard1_d = 1'b0;
            end else if (wr_ok && (wr_addr == rd_addr1)) begin
                rd_data1_d   = wr_data;
                rd_hazard1_d = 1'b0;
            end else begin
                rd_data1_d   = mem_q[rd_addr1];
                rd_hazard1_d = pend_q[rd_addr1];
            end
            if (zero2) begin
                rd_data2_d   = '0;
                rd_hazard2_d = 1'b0;
            end else if (wr_ok && (wr_addr == rd_addr2)) begin
                rd_data2_d   = wr_data;
                rd_hazard2_d = 1'b0;
            end else begin
                rd_data2_d   = mem_q[rd_addr2];
                rd_hazard2_d = pend_q[rd_addr2];
            end
        end
    end

    // Clear sequencer next state and pending-bit updates (reservation wins over write).
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pend_d  = pend_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    idx_d   = '0;
                end else begin
                    if (wr_ok) begin
                        pend_d[wr_addr] = 1'b0;
                    end
                    if (rsv_ok) begin
                        pend_d[rsv_addr] = 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                pend_d[idx_q] = 1'b0;
                idx_d         = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Population count of the next pending vector, so the count updates with the bits.
    always_comb begin
        pend_count_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pend_count_d = pend_count_d + (ADDR_W + 1)'(pend_d[i]);
        end
    end

    // Control, scoreboard and read-output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            pend_q       <= '0;
            pend_count_q <= '0;
            rd_data1_q   <= '0;
            rd_data2_q   <= '0;
            rd_valid_q   <= 1'b0;
            rd_hazard1_q <= 1'b0;
            rd_hazard2_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            pend_q       <= pend_d;
            pend_count_q <= pend_count_d;
            rd_data1_q   <= rd_data1_d;
            rd_data2_q   <= rd_data2_d;
            rd_valid_q   <= rd_valid_d;
            rd_hazard1_q <= rd_hazard1_d;
            rd_hazard2_q <= rd_hazard2_d;
        end
    end

    // Storage array: the clear sequencer owns the write port while it runs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (state_q == ST_CLEAR) begin
            mem_q[idx_q] <= '0;
        end else if (wr_ok) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data1   = rd_data1_q;
    assign rd_data2   = rd_data2_q;
    assign rd_valid   = rd_valid_q;
    assign rd_hazard1 = rd_hazard1_q;
    assign rd_hazard2 = rd_hazard2_q;
    assign busy       = (state_q == ST_CLEAR);
    assign pend_count = pend_count_q;

endmodule
`default_nettype wire
